// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, receiver state encoding and per-axis status record.
// Used by both the pong video generator and the frame receiver.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int CNT_W = 10;
    localparam int SUM_W = 16;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic sync_rise;
        logic period_err;
        logic width_err;
        logic sat_err;
        logic in_win;
    } axis_stat_t;

endpackage

// File: rtl/vga_rx_axis.sv
// One timing axis: saturating position counter cleared on sync assertion, period/width checks, window compare.
// Status is combinational from the registered count; no backpressure (advances whenever step is high).
module vga_rx_axis
    import vga_pkg::*;
#(
    parameter int TOTAL     = VGA_H_TOTAL,
    parameter int SYNC      = VGA_H_SYNC,
    parameter int WIN_START = VGA_H_SYNC + VGA_H_BP,
    parameter int WIN_LEN   = VGA_H_ACTIVE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             sync,
    output logic [CNT_W-1:0] pos,
    output axis_stat_t       stat
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SAT     = '1;
    localparam logic [CNT_W-1:0] SAT_M1  = SAT - ONE;
    localparam logic [CNT_W-1:0] TOT_M1  = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_M1 = CNT_W'(SYNC - 1);
    localparam logic [CNT_W-1:0] WIN_LO  = CNT_W'(WIN_START);
    localparam logic [CNT_W-1:0] WIN_HI  = CNT_W'(WIN_START + WIN_LEN);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sync_d;
    logic             rise;
    logic             fall;

    // sync_d only advances on step, so for the vertical axis it is the previous line's vsync
    assign rise = step & sync & ~sync_d;
    assign fall = step & ~sync & sync_d;

    always_comb begin
        cnt_nxt = cnt;
        if (rise) begin
            cnt_nxt = '0;
        end else if (step && (cnt != SAT)) begin
            cnt_nxt = cnt + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            sync_d <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (step) begin
                sync_d <= sync;
            end
        end
    end

    // cnt_nxt is the position of the sample presently held in the input register
    always_comb begin
        stat            = '0;
        stat.sync_rise  = rise;
        stat.period_err = rise && (cnt != TOT_M1);
        stat.width_err  = fall && (cnt != SYNC_M1);
        stat.sat_err    = step && !rise && (cnt == SAT_M1);
        stat.in_win     = (cnt_nxt >= WIN_LO) && (cnt_nxt < WIN_HI);
    end

    assign pos = cnt_nxt - WIN_LO;

endmodule

// File: rtl/vga_frame_receiver.sv
// VGA sink: recovers pixel coordinates, checks sync timing, reports lock, per-frame status and rgb checksum.
// Pixel outputs 2 clocks after the pin; status pulses 1 clock after edge detect; no backpressure.
module vga_frame_receiver
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int H_FP        = VGA_H_FP,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BP        = VGA_H_BP,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int V_FP        = VGA_V_FP,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BP        = VGA_V_BP,
    parameter int SYNC_POL    = 0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsync,
    input  logic             vsync,
    input  logic [5:0]       rgb,
    output logic             pix_valid,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic [5:0]       pix_rgb,
    output logic             locked,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [SUM_W-1:0] frame_sum,
    output logic             err
);

    localparam int         H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic       POL     = (SYNC_POL != 0);
    localparam logic [3:0] LOCK_N  = 4'(LOCK_FRAMES);

    logic                 s_hs;
    logic                 s_vs;
    logic [5:0]           s_rgb;
    logic [CNT_W-1:0]     h_pos;
    logic [CNT_W-1:0]     v_pos;
    axis_stat_t           h_stat;
    axis_stat_t           v_stat;
    logic                 err_any;
    logic                 frame_start;
    logic                 active;
    logic                 reporting;
    logic                 frame_err;
    logic                 frame_clean;
    logic [SUM_W-1:0]     acc;
    rx_state_t            state;
    rx_state_t            state_nxt;
    logic [3:0]           good;
    logic [3:0]           good_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_hs  <= 1'b0;
            s_vs  <= 1'b0;
            s_rgb <= '0;
        end else begin
            s_hs  <= (hsync == POL);
            s_vs  <= (vsync == POL);
            s_rgb <= rgb;
        end
    end

    vga_rx_axis #(
        .TOTAL     (H_TOTAL),
        .SYNC      (H_SYNC),
        .WIN_START (H_SYNC + H_BP),
        .WIN_LEN   (H_ACTIVE)
    ) u_h_axis (
        .clk  (clk),
        .rst  (rst),
        .step (1'b1),
        .sync (s_hs),
        .pos  (h_pos),
        .stat (h_stat)
    );

    // Vertical axis steps once per line; vsync is judged at the hsync assertion edge
    vga_rx_axis #(
        .TOTAL     (V_TOTAL),
        .SYNC      (V_SYNC),
        .WIN_START (V_SYNC + V_BP),
        .WIN_LEN   (V_ACTIVE)
    ) u_v_axis (
        .clk  (clk),
        .rst  (rst),
        .step (h_stat.sync_rise),
        .sync (s_vs),
        .pos  (v_pos),
        .stat (v_stat)
    );

    assign err_any     = h_stat.period_err | h_stat.width_err | h_stat.sat_err |
                         v_stat.period_err | v_stat.width_err | v_stat.sat_err;
    assign frame_start = v_stat.sync_rise;
    assign active      = h_stat.in_win & v_stat.in_win;
    assign reporting   = (state != SEARCH);
    // An error in the frame-start cycle itself belongs to the frame that is ending
    assign frame_clean = ~frame_err & ~err_any;

    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        unique case (state)
            SEARCH: begin
                if (frame_start) begin
                    state_nxt = ACQUIRE;
                    good_nxt  = '0;
                end
            end
            ACQUIRE: begin
                if (frame_start) begin
                    if (frame_clean) begin
                        good_nxt = good + 4'd1;
                        if ((good + 4'd1) == LOCK_N) begin
                            state_nxt = LOCKED;
                        end
                    end else begin
                        good_nxt = '0;
                    end
                end
            end
            LOCKED: begin
                if (err_any) begin
                    state_nxt = ACQUIRE;
                    good_nxt  = '0;
                end
            end
            default: begin
                state_nxt = SEARCH;
                good_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEARCH;
            good  <= '0;
        end else begin
            state <= state_nxt;
            good  <= good_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            acc       <= '0;
        end else begin
            if (frame_start) begin
                frame_err <= 1'b0;
                acc       <= '0;
            end else begin
                if (err_any && reporting) begin
                    frame_err <= 1'b1;
                end
                if (active) begin
                    acc <= acc + {{(SUM_W-6){1'b0}}, s_rgb};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err        <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            frame_sum  <= '0;
            locked     <= 1'b0;
        end else begin
            err        <= err_any & reporting;
            frame_done <= frame_start & reporting;
            locked     <= (state_nxt == LOCKED);
            if (frame_start && reporting) begin
                frame_ok  <= frame_clean;
                frame_sum <= acc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_rgb   <= '0;
        end else begin
            pix_valid <= active && (state_nxt == LOCKED);
            pix_x     <= active ? h_pos : '0;
            pix_y     <= active ? v_pos : '0;
            pix_rgb   <= s_rgb;
        end
    end

endmodule

// File: doc/vga_frame_receiver.md
# vga_frame_receiver

Synthesizable VGA sink for the pong design: samples the hsync/vsync/RGB pins driven by the pong video generator, recovers pixel coordinates, checks sync timing against 640x480@60 parameters, and reports lock, per-frame pass/fail and a per-frame pixel checksum. It sits at the far end of the video output, either in a loopback harness on the same clock or as a self-check block in the gate-level bench.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal porch and sync widths, in clocks
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical porch and sync widths, in lines
- SYNC_POL, 0: asserted sync level (0 = active-low)
- LOCK_FRAMES, 2: consecutive good frames required for lock (1..15)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- hsync  in  1  horizontal sync from generator
- vsync  in  1  vertical sync from generator
- rgb  in  6  {R1,R0,G1,G0,B1,B0}
- pix_valid  out  1  active-area pixel, locked only
- pix_x  out  10  column 0..H_ACTIVE-1
- pix_y  out  10  row 0..V_ACTIVE-1
- pix_rgb  out  6  sampled colour
- locked  out  1  timing lock
- frame_done  out  1  one-cycle pulse at each frame boundary
- frame_ok  out  1  last completed frame had no timing error
- frame_sum  out  16  sum mod 2^16 of rgb over last frame's active pixels
- err  out  1  one-cycle pulse on any timing violation

## Operation
- Inputs registered once (s_hs, s_vs, s_rgb); syncs normalised by SYNC_POL to active-high.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = 525.
- hsync assertion edge: hcnt <- 0, else hcnt+1, saturating at 1023. Line-length error if hcnt != H_TOTAL-1 at the edge, or if saturation is reached. Hsync-width error if the deassertion edge occurs at hcnt != H_SYNC-1.
- Line step on each hsync assertion edge. If s_vs is asserted and was not asserted on the previous line, that is a frame start: vcnt <- 0. Otherwise vcnt+1, saturating at 1023.
- Frame-start error if previous vcnt != V_TOTAL-1. Vsync-width error if the number of lines with s_vs asserted != V_SYNC.
- Active region: hcnt in [H_SYNC+H_BP, +H_ACTIVE) and vcnt in [V_SYNC+V_BP, +V_ACTIVE). pix_x and pix_y are offsets into that region.
- FSM states:
  - SEARCH: after reset; waits for the first frame start, then goes to ACQUIRE with good=0. No errors are reported in SEARCH.
  - ACQUIRE: at each frame start, good++ if the frame was clean, else good=0. When good reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: any error pulses err, drops locked the following cycle, and returns to ACQUIRE with good=0.
- err pulses in ACQUIRE and LOCKED. Multiple errors in the same cycle give a single pulse.
- frame_done pulses at every frame start except the first after SEARCH. frame_ok and frame_sum update in the same cycle and hold until the next frame_done.
- The sum accumulates all active pixels regardless of lock. The accumulator clears at frame start.

## Timing
- Reset: all outputs 0, state SEARCH, counters 0. A reset mid-frame discards the partial frame.
- Pixel latency is 2 clocks: rgb sampled at edge t+1 appears on pix_rgb/pix_x/pix_y/pix_valid after edge t+2.
- err, frame_done, frame_ok and frame_sum are registered: they are valid 1 clock after the edge-detect cycle, which is 2 clocks after the pin transition.
- locked rises in the same cycle as the frame_done that completes the LOCK_FRAMES-th good frame.
- pix_valid is low during the cycle locked rises if that cycle is outside the active area. In-frame pixels begin with the next frame.
- Simultaneous hsync and vsync assertion is the normal case: vsync is evaluated at the hsync edge.

## Structure
- Shared package vga_pkg holds:
  - default 640x480 timing constants, shared with the pong generator
  - derived H_TOTAL/V_TOTAL
  - rx state enum {SEARCH, ACQUIRE, LOCKED}
- One sub-module, vga_rx_axis, is instantiated twice (horizontal on every clock, vertical on the line step). It contains:
  - saturating counter with edge-triggered clear
  - period check and sync-width check
  - active-window compare

## Test plan
- Reset, then ideal frames with rgb=6'h3F:
  - locked rises at the frame_done ending the 2nd full frame
  - frame_sum = 16'h5000 (307200*63 mod 65536), frame_ok=1
- Gradient rgb = x[5:0]:
  - first pix_valid carries x=0, y=0 two clocks after the first active sample
  - last pixel is x=639, y=479, followed by exactly 307200 valid cycles per frame
- While locked, stretch one line to 801 clocks:
  - err pulses once, locked drops next cycle, frame_ok=0 at the next frame_done
  - locked restores after 2 further clean frames
- Hold hsync deasserted for 1100 clocks: hcnt saturates, err pulses, locked=0.
- Assert rst mid-frame while locked:
  - next cycle all outputs are 0
  - first post-reset frame_done occurs only after a full frame following the next vsync
- SYNC_POL=1 with inverted syncs: identical results to scenario 1.
